// File: rtl/sdu_run_ctrl.sv
// sdu_run_ctrl: CPU run controller for the serial debug unit.
// Produces a per-cycle CPU clock enable for step, run, run-N and host halt.
//
// Ports:
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_cmd_valid         command strobe; commands are always accepted
//   o_cmd_ready         tied high
//   i_cmd_op            0 NOP 1 STEP 2 RUN 3 RUN_N 4 HALT
//                       5 SET_BP 6 CLR_BP 7 SET_BP_MASK
//   i_cmd_arg           run count, breakpoint address or mask
//   i_cmd_idx           breakpoint slot for ops 5..7
//   i_pc                current CPU program counter
//   o_cpu_ce            CPU clock enable (combinational)
//   o_halted            CPU stopped
//   o_halt_cause        0 HOST 1 STEP 2 COUNT 3 BP
//   o_bp_hit_idx        lowest slot that matched on the last BP halt
//   o_bp_valid          per-slot breakpoint enable
//   o_retired           enabled cycles since launch, saturating
//
// Build option: define SDU_BP_MASK_EN to give every slot a don't-care
// mask; otherwise breakpoints are exact matches and op 7 does nothing.

module sdu_run_ctrl #(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 4,
    parameter int CNT_W  = 16,
    localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [2:0]        i_cmd_op,
    input  logic [XLEN-1:0]   i_cmd_arg,
    input  logic [IDX_W-1:0]  i_cmd_idx,
    input  logic [XLEN-1:0]   i_pc,
    output logic              o_cpu_ce,
    output logic              o_halted,
    output logic [1:0]        o_halt_cause,
    output logic [IDX_W-1:0]  o_bp_hit_idx,
    output logic [NUM_BP-1:0] o_bp_valid,
    output logic [CNT_W-1:0]  o_retired
);

    localparam logic [2:0] OP_STEP   = 3'd1;
    localparam logic [2:0] OP_RUN    = 3'd2;
    localparam logic [2:0] OP_RUN_N  = 3'd3;
    localparam logic [2:0] OP_HALT   = 3'd4;
    localparam logic [2:0] OP_SET_BP = 3'd5;
    localparam logic [2:0] OP_CLR_BP = 3'd6;
`ifdef SDU_BP_MASK_EN
    localparam logic [2:0] OP_SET_MASK = 3'd7;
`endif

    localparam logic [1:0] C_HOST  = 2'd0;
    localparam logic [1:0] C_STEP  = 2'd1;
    localparam logic [1:0] C_COUNT = 2'd2;
    localparam logic [1:0] C_BP    = 2'd3;

    typedef enum logic [1:0] {
        S_HALTED,
        S_STEP,
        S_RUN,
        S_RUNN
    } state_t;

    state_t             r_state;
    logic               r_first;
    logic [CNT_W-1:0]   r_remaining;
    logic [1:0]         r_cause;
    logic [IDX_W-1:0]   r_hit_idx;
    logic [CNT_W-1:0]   r_retired;
    logic [NUM_BP-1:0]  r_bp_valid;
    logic [XLEN-1:0]    r_bp_addr [NUM_BP];
`ifdef SDU_BP_MASK_EN
    logic [XLEN-1:0]    r_bp_mask [NUM_BP];
`endif

    logic [NUM_BP-1:0]  w_match;
    logic [NUM_BP-1:0]  w_hits;
    logic               w_bp_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_cpu_ce;
    logic               w_do_step;
    logic               w_do_run;
    logic               w_do_runn;
    logic               w_do_halt;
    logic               w_launch;
    logic               w_count_done;
    logic               w_ret_sat;
    logic [CNT_W-1:0]   w_count;

    // ---------------- command decode ----------------
    assign w_do_step = i_cmd_valid && (i_cmd_op == OP_STEP);
    assign w_do_run  = i_cmd_valid && (i_cmd_op == OP_RUN);
    assign w_do_runn = i_cmd_valid && (i_cmd_op == OP_RUN_N);
    assign w_do_halt = i_cmd_valid && (i_cmd_op == OP_HALT);
    assign w_count   = i_cmd_arg[CNT_W-1:0];

    // Launch commands only count while stopped; while running they are dropped.
    assign w_launch = (r_state == S_HALTED) &&
                      (w_do_step || w_do_run || w_do_runn);

    // ---------------- breakpoint compare ----------------
    always_comb begin
        for (int i = 0; i < NUM_BP; i++) begin
`ifdef SDU_BP_MASK_EN
            w_match[i] = ((i_pc ^ r_bp_addr[i]) & ~r_bp_mask[i]) == '0;
`else
            w_match[i] = (i_pc == r_bp_addr[i]);
`endif
        end
    end

    assign w_hits   = w_match & r_bp_valid;
    assign w_bp_hit = |w_hits;

    // Scan downwards so the lowest matching slot is the one left standing.
    always_comb begin
        w_hit_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_hits[i]) begin
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // ---------------- clock enable ----------------
    // The first running cycle is never suppressed so the CPU can step off
    // the breakpoint it stopped on.
    always_comb begin
        w_cpu_ce = 1'b0;
        unique case (r_state)
            S_STEP:        w_cpu_ce = 1'b1;
            S_RUN, S_RUNN: w_cpu_ce = !(w_bp_hit && !r_first);
            default:       w_cpu_ce = 1'b0;
        endcase
    end

    assign w_count_done = (r_state == S_RUNN) && w_cpu_ce &&
                          (r_remaining == CNT_W'(1));
    assign w_ret_sat    = &r_retired;

    // ---------------- run state machine ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_HALTED;
            r_first     <= 1'b0;
            r_remaining <= '0;
            r_cause     <= C_HOST;
            r_hit_idx   <= '0;
            r_retired   <= '0;
        end else begin
            if (w_launch) begin
                r_retired <= '0;
            end else if (w_cpu_ce && !w_ret_sat) begin
                r_retired <= r_retired + CNT_W'(1);
            end

            unique case (r_state)
                S_HALTED: begin
                    if (w_do_step) begin
                        r_state <= S_STEP;
                    end else if (w_do_run) begin
                        r_state <= S_RUN;
                        r_first <= 1'b1;
                    end else if (w_do_runn) begin
                        if (w_count == '0) begin
                            r_cause <= C_COUNT;
                        end else begin
                            r_state     <= S_RUNN;
                            r_remaining <= w_count;
                            r_first     <= 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    r_state <= S_HALTED;
                    r_cause <= C_STEP;
                end
                S_RUN, S_RUNN: begin
                    r_first <= 1'b0;
                    if ((r_state == S_RUNN) && w_cpu_ce) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                    // Host halt beats count expiry, which beats a breakpoint;
                    // an expiring count means the enable fired, so no BP stop.
                    if (w_do_halt) begin
                        r_state <= S_HALTED;
                        r_cause <= C_HOST;
                    end else if (w_count_done) begin
                        r_state <= S_HALTED;
                        r_cause <= C_COUNT;
                    end else if (!w_cpu_ce) begin
                        r_state   <= S_HALTED;
                        r_cause   <= C_BP;
                        r_hit_idx <= w_hit_idx;
                    end
                end
                default: begin
                    r_state <= S_HALTED;
                end
            endcase
        end
    end

    // ---------------- breakpoint registers ----------------
    // Slot writes are honoured in every state; an index past the last slot
    // matches no loop iteration and is therefore dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bp_valid <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                r_bp_addr[i] <= '0;
`ifdef SDU_BP_MASK_EN
                r_bp_mask[i] <= '0;
`endif
            end
        end else if (i_cmd_valid) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (i_cmd_idx == IDX_W'(i)) begin
                    if (i_cmd_op == OP_SET_BP) begin
                        r_bp_addr[i]  <= i_cmd_arg;
                        r_bp_valid[i] <= 1'b1;
                    end
                    if (i_cmd_op == OP_CLR_BP) begin
                        r_bp_valid[i] <= 1'b0;
                    end
`ifdef SDU_BP_MASK_EN
                    if (i_cmd_op == OP_SET_MASK) begin
                        r_bp_mask[i] <= i_cmd_arg;
                    end
`endif
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign o_cmd_ready  = 1'b1;
    assign o_cpu_ce     = w_cpu_ce;
    assign o_halted     = (r_state == S_HALTED);
    assign o_halt_cause = r_cause;
    assign o_bp_hit_idx = r_hit_idx;
    assign o_bp_valid   = r_bp_valid;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_sdu_run_ctrl.sv
// tb_sdu_run_ctrl: self-checking bench for sdu_run_ctrl.
// Vector table, directed multi-cycle sequences and a random run vs a model.

module tb_sdu_run_ctrl;

    localparam int XLEN   = 32;
    localparam int NUM_BP = 4;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = 2;

    localparam int M_HALT = 0;
    localparam int M_STEP = 1;
    localparam int M_RUN  = 2;
    localparam int M_RUNN = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [XLEN-1:0]   cmd_arg = '0;
    logic [IDX_W-1:0]  cmd_idx = '0;
    logic [XLEN-1:0]   pc = '0;
    logic              cpu_ce;
    logic              halted;
    logic [1:0]        halt_cause;
    logic [IDX_W-1:0]  bp_hit_idx;
    logic [NUM_BP-1:0] bp_valid;
    logic [CNT_W-1:0]  retired;

    int checks = 0;
    int failures = 0;

    sdu_run_ctrl #(.XLEN(XLEN), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_op     (cmd_op),
        .i_cmd_arg    (cmd_arg),
        .i_cmd_idx    (cmd_idx),
        .i_pc         (pc),
        .o_cpu_ce     (cpu_ce),
        .o_halted     (halted),
        .o_halt_cause (halt_cause),
        .o_bp_hit_idx (bp_hit_idx),
        .o_bp_valid   (bp_valid),
        .o_retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode;
    bit          m_first;
    int          m_rem;
    int          m_cause;
    int          m_hit;
    int          m_ret;
    bit [3:0]    m_bpv;
    logic [31:0] m_addr [4];
    logic [31:0] m_mask [4];
    logic [31:0] pc_m;
    int          pulses;

    task automatic m_reset();
        m_mode  = M_HALT;
        m_first = 0;
        m_rem   = 0;
        m_cause = 0;
        m_hit   = 0;
        m_ret   = 0;
        m_bpv   = '0;
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = '0;
            m_mask[i] = '0;
        end
    endtask

    function automatic bit m_match(input int i, input logic [31:0] p);
`ifdef SDU_BP_MASK_EN
        return ((p | m_mask[i]) == (m_addr[i] | m_mask[i]));
`else
        return p == m_addr[i];
`endif
    endfunction

    function automatic int m_lowest(input logic [31:0] p);
        for (int i = 0; i < 4; i++)
            if (m_bpv[i] && m_match(i, p)) return i;
        return -1;
    endfunction

    function automatic bit m_ce(input logic [31:0] p);
        if (m_mode == M_STEP) return 1'b1;
        if (m_mode == M_RUN || m_mode == M_RUNN)
            return m_first || (m_lowest(p) < 0);
        return 1'b0;
    endfunction

    task automatic m_update(input bit v, input int op, input logic [31:0] arg,
                            input int idx, input bit ce, input logic [31:0] p);
        int lo;
        int n;
        lo = m_lowest(p);
        n  = int'(arg[15:0]);
        if (v && m_mode == M_HALT && (op == 1 || op == 2 || op == 3))
            m_ret = 0;
        else if (ce && m_ret < 65535)
            m_ret++;
        case (m_mode)
            M_HALT: if (v) begin
                if (op == 1) m_mode = M_STEP;
                else if (op == 2) begin m_mode = M_RUN; m_first = 1; end
                else if (op == 3) begin
                    if (n == 0) m_cause = 2;
                    else begin m_mode = M_RUNN; m_rem = n; m_first = 1; end
                end
            end
            M_STEP: begin m_mode = M_HALT; m_cause = 1; end
            default: begin
                m_first = 0;
                if (v && op == 4) begin m_mode = M_HALT; m_cause = 0; end
                else if (m_mode == M_RUNN && ce && m_rem == 1) begin
                    m_mode = M_HALT; m_cause = 2;
                end else if (!ce) begin
                    m_mode = M_HALT; m_cause = 3; m_hit = lo;
                end
                if (m_mode == M_RUNN && ce) m_rem--;
            end
        endcase
        if (v && idx < NUM_BP) begin
            if (op == 5) begin m_addr[idx] = arg; m_bpv[idx] = 1; end
            if (op == 6) m_bpv[idx] = 0;
`ifdef SDU_BP_MASK_EN
            if (op == 7) m_mask[idx] = arg;
`endif
        end
    endtask

    // One clock: drive at +1 after posedge, check enable, clock, check state.
    task automatic cyc(input bit v, input int op, input logic [31:0] arg,
                       input int idx);
        bit ce;
        cmd_valid = v;
        cmd_op    = 3'(op);
        cmd_arg   = arg;
        cmd_idx   = IDX_W'(idx);
        pc        = pc_m;
        #1;
        ce = m_ce(pc_m);
        chk("cpu_ce", cpu_ce, ce);
        if (cpu_ce) pulses++;
        m_update(v, op, arg, idx, ce, pc_m);
        if (ce) pc_m = pc_m + 4;
        @(posedge clk);
        #1;
        cmd_valid = 0;
        chk("halted", halted, m_mode == M_HALT);
        chk("halt_cause", halt_cause, m_cause);
        chk("retired", retired, m_ret);
        chk("bp_valid", bp_valid, m_bpv);
        chk("bp_hit_idx", bp_hit_idx, m_hit);
    endtask

    task automatic do_reset();
        rst = 1;
        cmd_valid = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 0;
        m_reset();
    endtask

    task automatic wait_halt(input string name, input int budget);
        bit done;
        done = halted;
        for (int k = 0; k < budget && !done; k++) begin
            cyc(0, 0, 0, 0);
            done = halted;
        end
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL %s timeout actual=running expected=halted", name);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] arg;
        logic [1:0]  idx;
        logic [31:0] p;
        logic        ce;
        logic        hlt;
        logic [1:0]  cause;
        logic [15:0] ret;
        logic [3:0]  bpv;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(logic v, logic [2:0] op, logic [31:0] arg,
                                logic [1:0] idx, logic [31:0] p, logic ce,
                                logic hlt, logic [1:0] cause,
                                logic [15:0] ret, logic [3:0] bpv);
        vec_t t;
        t.v = v; t.op = op; t.arg = arg; t.idx = idx; t.p = p;
        t.ce = ce; t.hlt = hlt; t.cause = cause; t.ret = ret; t.bpv = bpv;
        return t;
    endfunction

    initial begin
        tbl[0]  = mk(0, 0, 0,     0, 0,     0, 1, 0, 0, 4'h0);
        tbl[1]  = mk(1, 1, 0,     0, 0,     0, 0, 0, 0, 4'h0);
        tbl[2]  = mk(0, 0, 0,     0, 0,     1, 1, 1, 1, 4'h0);
        tbl[3]  = mk(1, 1, 0,     0, 4,     0, 0, 1, 0, 4'h0);
        tbl[4]  = mk(0, 0, 0,     0, 4,     1, 1, 1, 1, 4'h0);
        tbl[5]  = mk(1, 3, 0,     0, 8,     0, 1, 2, 0, 4'h0);
        tbl[6]  = mk(1, 4, 0,     0, 8,     0, 1, 2, 0, 4'h0);
        tbl[7]  = mk(1, 5, 8,     0, 8,     0, 1, 2, 0, 4'h1);
        tbl[8]  = mk(1, 6, 0,     0, 8,     0, 1, 2, 0, 4'h0);
        tbl[9]  = mk(1, 5, 32'h20, 3, 8,    0, 1, 2, 0, 4'h8);
        tbl[10] = mk(1, 1, 0,     0, 32'h20, 0, 0, 2, 0, 4'h8);
        tbl[11] = mk(0, 0, 0,     0, 32'h20, 1, 1, 1, 1, 4'h8);
        tbl[12] = mk(1, 6, 0,     3, 32'h20, 0, 1, 1, 1, 4'h0);

        m_reset();
        pc_m = 0;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            cmd_valid = tbl[i].v;
            cmd_op    = tbl[i].op;
            cmd_arg   = tbl[i].arg;
            cmd_idx   = tbl[i].idx;
            pc        = tbl[i].p;
            #1;
            chk($sformatf("tbl%0d.cpu_ce", i), cpu_ce, tbl[i].ce);
            chk($sformatf("tbl%0d.ready", i), cmd_ready, 1);
            @(posedge clk);
            #1;
            cmd_valid = 0;
            chk($sformatf("tbl%0d.halted", i), halted, tbl[i].hlt);
            chk($sformatf("tbl%0d.cause", i), halt_cause, tbl[i].cause);
            chk($sformatf("tbl%0d.retired", i), retired, tbl[i].ret);
            chk($sformatf("tbl%0d.bp_valid", i), bp_valid, tbl[i].bpv);
        end

        // Idle after reset: nothing moves.
        do_reset();
        pc_m = 0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);

        // Three STEPs back to back, retired is 1 after each.
        for (int i = 0; i < 3; i++) begin
            pulses = 0;
            cyc(1, 1, 0, 0);
            cyc(0, 0, 0, 0);
            chk("step.pulses", pulses, 1);
            chk("step.retired", retired, 1);
            chk("step.cause", halt_cause, 1);
        end

        // Breakpoint at 0x10 from pc 0: four pulses, then BP halt on slot 1.
        do_reset();
        pc_m = 0;
        cyc(1, 5, 32'h10, 1);
        pulses = 0;
        cyc(1, 2, 0, 0);
        wait_halt("bp_run", 100);
        chk("bp.pulses", pulses, 4);
        chk("bp.cause", halt_cause, 3);
        chk("bp.hit_idx", bp_hit_idx, 1);
        chk("bp.retired", retired, 4);

        // Resume from the breakpoint PC, then host halt 20 cycles later.
        pulses = 0;
        cyc(1, 2, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
        cyc(1, 4, 0, 0);
        chk("resume.pulses", pulses, 21);
        chk("host.halted", halted, 1);
        chk("host.cause", halt_cause, 0);

        // RUN_N 7 then RUN_N 0.
        do_reset();
        pc_m = 0;
        pulses = 0;
        cyc(1, 3, 7, 0);
        wait_halt("runn7", 50);
        chk("runn7.pulses", pulses, 7);
        chk("runn7.cause", halt_cause, 2);
        chk("runn7.retired", retired, 7);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        pulses = 0;
        cyc(1, 3, 0, 0);
        chk("runn0.pulses", pulses, 0);
        chk("runn0.halted", halted, 1);
        chk("runn0.cause", halt_cause, 2);

        // Reset while running.
        cyc(1, 5, 32'h400, 2);
        cyc(1, 2, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        m_reset();
        #1;
        chk("rst.cpu_ce", cpu_ce, 0);
        chk("rst.bp_valid", bp_valid, 0);
        chk("rst.halted", halted, 1);

        // Masked slot 0 at 0x100/0xF: exact hit at 0x100 in both builds.
        @(posedge clk);
        #1;
        pc_m = 32'hF0;
        cyc(1, 5, 32'h100, 0);
        cyc(1, 7, 32'hF, 0);
        pulses = 0;
        cyc(1, 2, 0, 0);
        wait_halt("mask_a", 50);
        chk("mask_a.pulses", pulses, 4);
        chk("mask_a.cause", halt_cause, 3);

        // From 0x108: 0x10C only matches when the mask exists.
        pc_m = 32'h108;
        pulses = 0;
        cyc(1, 2, 0, 0);
`ifdef SDU_BP_MASK_EN
        wait_halt("mask_b", 10);
        chk("mask_b.pulses", pulses, 1);
        chk("mask_b.cause", halt_cause, 3);
        chk("mask_b.hit_idx", bp_hit_idx, 0);
`else
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        chk("mask_b.running", halted, 0);
        cyc(1, 4, 0, 0);
        chk("mask_b.pulses", pulses, 11);
        chk("mask_b.cause", halt_cause, 0);
`endif

        // Random traffic against the model.
        do_reset();
        pc_m = 0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [31:0] a;
            int ix;
            r  = int'($urandom_range(0, 99));
            ix = int'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 5) pc_m = 32'($urandom_range(0, 15)) << 2;
            if (r < 40) begin
                cyc(r < 30 ? 1'b0 : 1'b1, 0, $urandom, ix);
            end else if (r < 50) begin
                cyc(1, 1, $urandom, ix);
            end else if (r < 56) begin
                cyc(1, 2, $urandom, ix);
            end else if (r < 68) begin
                a = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 12));
                cyc(1, 3, a, ix);
            end else if (r < 76) begin
                cyc(1, 4, $urandom, ix);
            end else if (r < 88) begin
                cyc(1, 5, 32'($urandom_range(0, 15)) << 2, ix);
            end else if (r < 94) begin
                cyc(1, 6, $urandom, ix);
            end else begin
                cyc(1, 7, 32'($urandom_range(0, 15)), ix);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdu_run_ctrl.md
Name: sdu_run_ctrl

Overview:
- Parametrised CPU run controller for the serial debug unit. It replaces the single free/stepped CPU clock with a per-cycle clock enable (cpu_ce).
- Supports single step, free run, run-N-instructions, and host halt.
- Has NUM_BP programmable PC breakpoints, plus halt-cause and retired-count reporting.
- Sits between the SDU command decoder and the CPU; pc comes from the CPU's current PC.

Parameters:
- XLEN, 32, PC/address width
- NUM_BP, 4, number of PC breakpoint slots (1..16)
- CNT_W, 16, width of run-N count and retired counter
- (derived) IDX_W = max(1, clog2(NUM_BP))

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command strobe from SDU
- cmd_ready  out  1  constant 1 (every command is accepted in one cycle)
- cmd_op  in  3  0 NOP, 1 STEP, 2 RUN, 3 RUN_N, 4 HALT, 5 SET_BP, 6 CLR_BP, 7 SET_BP_MASK
- cmd_arg  in  XLEN  RUN_N count (low CNT_W bits), SET_BP address, or SET_BP_MASK mask
- cmd_idx  in  IDX_W  breakpoint slot for ops 5/6/7
- pc  in  XLEN  current CPU PC
- cpu_ce  out  1  CPU clock enable; one CPU cycle per high clk cycle
- halted  out  1  1 while CPU is stopped
- halt_cause  out  2  0 HOST, 1 STEP, 2 COUNT, 3 BP
- bp_hit_idx  out  IDX_W  lowest matching slot on the last BP halt
- bp_valid  out  NUM_BP  per-slot enable
- retired  out  CNT_W  cpu_ce pulses since the last STEP/RUN/RUN_N acceptance; saturates at all-ones

Behaviour:
- Accept means cmd_valid=1 in cycle T; the command takes effect at T+1.
- States: HALTED, STEP, RUN, RUNN. All state and outputs are registered, except cpu_ce.
- cpu_ce is combinational from registered state and pc. It is asserted only in STEP, RUN or RUNN, and only when not suppressed by a breakpoint.
- Reset:
  - state HALTED, halted=1, halt_cause=HOST, bp_hit_idx=0.
  - bp_valid=0, all bp addresses 0, retired=0, cpu_ce=0, remaining count 0.
  - A reset mid-run stops cpu_ce the following cycle and clears all breakpoints.
- HALTED state:
  - STEP: retired cleared; state STEP at T+1. cpu_ce=1 for exactly cycle T+1. At T+2: HALTED, cause STEP, retired=1. Breakpoints are ignored for STEP.
  - RUN: retired cleared; state RUN at T+1; first-cycle flag set.
  - RUN_N with count n:
    - n=0: stay HALTED, set cause COUNT at T+1, no cpu_ce.
    - n>0: state RUNN, remaining=n, first-cycle flag set.
  - HALT and NOP: no effect; cause is unchanged.
- RUN and RUNN states:
  - bp_hit = OR over slots of (bp_valid[i] && match_i).
  - cpu_ce = !(bp_hit && !first). The first cycle after launch is always enabled, so the CPU can resume from a breakpoint PC. first clears after one cycle.
  - On a suppressed cycle: next cycle HALTED, cause BP, bp_hit_idx = lowest matching index.
  - In RUNN, each cpu_ce decrements remaining. When cpu_ce fires with remaining=1, next cycle HALTED with cause COUNT.
  - If the count expires and a breakpoint matches in the same cycle, COUNT wins: the enable fired, so no BP halt.
  - HALT accepted at T: cpu_ce is still evaluated normally in T; HALTED with cause HOST at T+1. HALT outranks a same-cycle COUNT or BP transition.
  - STEP, RUN and RUN_N are accepted but ignored while running.
  - SET_BP, CLR_BP and SET_BP_MASK are applied in any state; a new breakpoint is compared from T+1.
- Breakpoint writes:
  - SET_BP writes bp_addr[cmd_idx]=cmd_arg and sets bp_valid[cmd_idx].
  - CLR_BP clears bp_valid[cmd_idx].
  - cmd_idx >= NUM_BP: ignored.
- retired increments on every cpu_ce and is held at all-ones once saturated.
- halted = (state==HALTED).

Optional Feature:
- Macro SDU_BP_MASK_EN.
- Defined:
  - Each slot has an XLEN mask register, reset 0. SET_BP_MASK writes mask[cmd_idx]=cmd_arg; SET_BP leaves the mask unchanged.
  - match_i = ((pc ^ bp_addr[i]) & ~mask[i]) == 0.
- Undefined:
  - No mask registers; match_i = (pc == bp_addr[i]); op 7 is a NOP.

Test Plan:
- Reset, then idle 5 cycles -> halted=1, cause=0, cpu_ce never high, bp_valid=0, retired=0.
- STEP at T -> cpu_ce high only at T+1; at T+2 halted=1, cause=1, retired=1. Three STEPs in a row -> retired=1 after each.
- SET_BP idx1=0x0000_0010; pc model advances by 4 per cpu_ce starting at 0; RUN -> exactly 4 pulses, halt with cause=3, bp_hit_idx=1. A second RUN (pc=0x10) -> the first pulse is taken and the CPU moves past the breakpoint.
- RUN_N 7 with no breakpoints -> exactly 7 cpu_ce pulses, cause=2, retired=7. RUN_N 0 -> zero pulses, cause=2 the next cycle.
- RUN, then HALT 20 cycles later -> halted=1 the next cycle, cause=0. Assert rst mid-RUN -> cpu_ce low the next cycle, bp_valid=0.
- With SDU_BP_MASK_EN: bp0=0x100, mask 0xF -> halts at pc=0x100 on the first pulse-free match. pc=0x10C with bp0=0x100 also matches; without the macro the same run does not halt at 0x10C.
